// File: rtl/tft_rx_decoder.sv
// tft_rx_decoder: receive-side timing decoder for the TFT parallel bundle.
// Registers hs/vs/de/rgb, recovers pixel coordinates, measures line and
// frame periods and tracks lock (IDLE -> TRAIN -> LOCKED) on clean frames.
module tft_rx_decoder #(
  parameter logic [10:0] H_PERIOD    = 11'd1057,
  parameter logic [10:0] V_PERIOD    = 11'd526,
  parameter logic [10:0] H_ACT       = 11'd800,
  parameter logic [10:0] V_ACT       = 11'd480,
  parameter int unsigned DE_LEAD     = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        tft_hs,
  input  logic        tft_vs,
  input  logic        tft_de,
  input  logic [15:0] tft_rgb,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [15:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas
);

  localparam logic [10:0] C_MAX  = 11'h7FF;
  localparam logic [2:0]  C_LOCK = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_LOCKED} state_t;

  // input stage and one-cycle-old copies for edge detection
  logic        r_hs, r_vs, r_de, r_de_d;
  logic        r_hs_d, r_vs_d, r_deq_d;
  logic [15:0] r_rgb;

  // measurement counters
  logic [10:0] r_hcnt, r_vcnt, r_xcnt, r_ycnt, r_xlat;
  logic [10:0] r_h_meas, r_v_meas;
  logic        r_line_act, r_frame_dirty;

  // lock FSM
  state_t      r_state, w_state_nx;
  logic [2:0]  r_good, w_good_nx;

  // pixel output stage
  logic        r_pix_valid, r_frame_start, r_fs_pend;
  logic [10:0] r_pix_x, r_pix_y;
  logic [15:0] r_pix_data;

  logic        w_deq, w_hs_fall, w_vs_fall, w_deq_rise, w_deq_fall;
  logic        w_h_sat, w_line_bad, w_h_err, w_frame_bad;
  logic        w_locked, w_terr, w_issue;
  logic [10:0] w_line_px, w_lines, w_x;

  // de qualifier: with DE_LEAD=1 de runs one cycle ahead of rgb, so the
  // registered de is delayed once more to line up with the registered rgb
  assign w_deq      = (DE_LEAD == 0) ? r_de : r_de_d;

  assign w_hs_fall  = r_hs_d & ~r_hs;
  assign w_vs_fall  = r_vs_d & ~r_vs;
  assign w_deq_rise = w_deq & ~r_deq_d;
  assign w_deq_fall = ~w_deq & r_deq_d;

  // Register all inputs once, plus previous values for edge detection
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_de    <= 1'b0;
      r_de_d  <= 1'b0;
      r_rgb   <= '0;
      r_hs_d  <= 1'b0;
      r_vs_d  <= 1'b0;
      r_deq_d <= 1'b0;
    end else begin
      r_hs    <= tft_hs;
      r_vs    <= tft_vs;
      r_de    <= tft_de;
      r_de_d  <= r_de;
      r_rgb   <= tft_rgb;
      r_hs_d  <= r_hs;
      r_vs_d  <= r_vs;
      r_deq_d <= w_deq;
    end
  end

  // Line period: cycles between hs falls, restart at 1, saturate at max
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt   <= '0;
      r_h_meas <= '0;
    end else if (w_hs_fall) begin
      r_hcnt   <= 11'd1;
      r_h_meas <= r_hcnt;
    end else if (r_hcnt != C_MAX) begin
      r_hcnt   <= r_hcnt + 11'd1;
    end
  end

  // Frame period in lines. A coincident hs fall is the first line of the
  // new frame, so the restart value is 1 in that case.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt   <= '0;
      r_v_meas <= '0;
    end else if (w_vs_fall) begin
      r_vcnt   <= w_hs_fall ? 11'd1 : 11'd0;
      r_v_meas <= r_vcnt;
    end else if (w_hs_fall && r_vcnt != C_MAX) begin
      r_vcnt   <= r_vcnt + 11'd1;
    end
  end

  // Pixel count per de burst; holds the number of de_q cycles at de_q fall
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_xcnt <= '0;
      r_xlat <= '0;
    end else begin
      if (w_deq_rise)
        r_xcnt <= 11'd1;
      else if (w_deq && r_xcnt != C_MAX)
        r_xcnt <= r_xcnt + 11'd1;
      if (w_deq_fall)
        r_xlat <= r_xcnt;
    end
  end

  // Active line count: one per de_q fall, cleared at each vs fall
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)
      r_ycnt <= '0;
    else if (w_vs_fall)
      r_ycnt <= '0;
    else if (w_deq_fall && r_ycnt != C_MAX)
      r_ycnt <= r_ycnt + 11'd1;
  end

  // Remember whether the current line carried any de, so blanking lines
  // are checked on period only
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)
      r_line_act <= 1'b0;
    else if (w_hs_fall)
      r_line_act <= w_deq;
    else if (w_deq)
      r_line_act <= 1'b1;
  end

  // Line and frame checks, all on pre-restart counter values. The pixel
  // count falls through when de_q drops on the very hs fall cycle.
  assign w_line_px   = w_deq_fall ? r_xcnt : r_xlat;
  assign w_lines     = r_ycnt + {10'd0, w_deq_fall};
  assign w_h_sat     = ~w_hs_fall & (r_hcnt == C_MAX - 11'd1);
  assign w_line_bad  = w_hs_fall &
                       ((r_hcnt != H_PERIOD) |
                        (r_line_act & (w_line_px != H_ACT)));
  assign w_h_err     = w_line_bad | w_h_sat;
  assign w_frame_bad = w_vs_fall &
                       (r_frame_dirty | w_h_err |
                        (r_vcnt != V_PERIOD) | (w_lines != V_ACT));

  // Sticky per-frame dirty flag; a line failing on the vs fall cycle
  // belongs to the frame just ended and is folded into w_frame_bad
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)
      r_frame_dirty <= 1'b0;
    else if (w_vs_fall)
      r_frame_dirty <= 1'b0;
    else if (w_h_err)
      r_frame_dirty <= 1'b1;
  end

  // FSM state and clean-frame counter
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_good  <= w_good_nx;
    end
  end

  // FSM next state: train on clean frames, drop to TRAIN on any mismatch
  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good;
    case (r_state)
      S_IDLE: begin
        if (w_vs_fall) begin
          w_state_nx = S_TRAIN;
          w_good_nx  = '0;
        end
      end
      S_TRAIN: begin
        if (w_vs_fall) begin
          if (w_frame_bad) begin
            w_good_nx = '0;
          end else begin
            w_good_nx = r_good + 3'd1;
            if ((r_good + 3'd1) >= C_LOCK)
              w_state_nx = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        if (w_h_err || w_frame_bad) begin
          w_state_nx = S_TRAIN;
          w_good_nx  = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_good_nx  = '0;
      end
    endcase
  end

  // FSM outputs: lock indication and the error pulse
  always_comb begin
    w_locked = (r_state == S_LOCKED);
    w_terr   = w_locked & (w_h_err | w_frame_bad);
  end

  assign w_issue = w_deq & w_locked;
  assign w_x     = w_deq_rise ? 11'd0 : r_xcnt;

  // Pixel output: coordinates and data move only with a qualified pixel
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_data    <= '0;
      r_frame_start <= 1'b0;
      r_fs_pend     <= 1'b0;
    end else begin
      r_pix_valid   <= w_issue;
      r_frame_start <= w_issue & (r_fs_pend | w_vs_fall);
      if (w_issue) begin
        r_pix_x    <= w_x;
        r_pix_y    <= r_ycnt;
        r_pix_data <= r_rgb;
        r_fs_pend  <= 1'b0;
      end else if (w_vs_fall) begin
        r_fs_pend  <= 1'b1;
      end
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_data    = r_pix_data;
  assign frame_start = r_frame_start;
  assign locked      = w_locked;
  assign timing_err  = w_terr;
  assign h_meas      = r_h_meas;
  assign v_meas      = r_v_meas;

endmodule

// File: tb/tb_tft_rx_decoder.sv
// tb_tft_rx_decoder: directed bench on a shrunken raster (20x10 totals,
// 8x4 active, hs/vs width 2, de at columns 5..12 leading rgb by 1).
module tb_tft_rx_decoder;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b0;
  logic        tft_hs  = 1'b1;
  logic        tft_vs  = 1'b1;
  logic        tft_de  = 1'b0;
  logic [15:0] tft_rgb = '0;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [10:0] pix_x, pix_y, h_meas, v_meas;
  logic [15:0] pix_data;

  tft_rx_decoder #(
    .H_PERIOD(11'd20), .V_PERIOD(11'd10), .H_ACT(11'd8), .V_ACT(11'd4),
    .DE_LEAD(1), .LOCK_FRAMES(2)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .tft_hs(tft_hs), .tft_vs(tft_vs),
    .tft_de(tft_de), .tft_rgb(tft_rgb), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .h_meas(h_meas), .v_meas(v_meas)
  );

  always #5 clk_vga = ~clk_vga;

  int total = 0;
  int bad   = 0;

  // generator state (written only by the stimulus process)
  int gh = 2, gv = 5;
  int stretch_v = -1, drop_v = -1, drop_x = 0, hs_hold = 0, vs_edges = 0;

  // stream monitor (written only by the monitor process)
  int pv_cnt = 0, fs_cnt = 0, fs_ok = 1, pat_bad = 0, terr_cnt = 0;

  always @(negedge clk_vga) begin
    if (pix_valid) begin
      pv_cnt++;
      if (pix_data !== {pix_y[4:0], pix_x}) pat_bad++;
    end
    if (frame_start) begin
      fs_cnt++;
      if (!(pix_valid && pix_x == 11'd0 && pix_y == 11'd0)) fs_ok = 0;
    end
    if (timing_err) terr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one raster position, clock it in, advance the raster
  task automatic step();
    int hl;
    logic act;
    logic [10:0] xx;
    logic [4:0]  yy;
    hl  = (gv == stretch_v) ? 21 : 20;
    act = (gv >= 3 && gv < 7);
    xx  = 11'(gh - 6);
    yy  = 5'(gv - 3);
    tft_hs  = !(gh < 2 && hs_hold == 0);
    tft_vs  = !(gv < 2 && hs_hold == 0);
    tft_de  = act && gh >= 5 && gh < 13 && !(gv == drop_v && gh - 5 == drop_x);
    tft_rgb = (act && gh >= 6 && gh < 14) ? {yy, xx} : 16'h0;
    if (gv == 0 && gh == 0 && hs_hold == 0) vs_edges++;
    @(posedge clk_vga);
    #1;
    if (hs_hold > 0) hs_hold--;
    gh++;
    if (gh >= hl) begin
      gh = 0;
      if (gv == stretch_v) stretch_v = -1;
      if (gv == drop_v) drop_v = -1;
      gv = (gv == 9) ? 0 : gv + 1;
    end
  endtask

  task automatic run_to_vs(input int target);
    int n = 0;
    while (vs_edges < target && n < 5000) begin step(); n++; end
    chk("vs_reached", 32'(vs_edges), 32'(target));
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    while (!(gv == v && gh == h) && n < 5000) begin step(); n++; end
    chk("pos_reached", 32'(gv * 100 + gh), 32'(v * 100 + h));
  endtask

  initial begin
    int pv0, fs0, pb0, te0;

    // reset state
    repeat (4) step();
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timing_err", 32'(timing_err), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_h_meas", 32'(h_meas), 0);
    chk("rst_v_meas", 32'(v_meas), 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    rst_n = 1'b1;

    // lock at the third vs fall, one cycle after it is registered
    run_to_vs(3);
    chk("lock_not_yet", 32'(locked), 0);
    step();
    chk("lock_rise", 32'(locked), 1);
    chk("lock_h_meas", 32'(h_meas), 20);
    chk("lock_v_meas", 32'(v_meas), 10);

    // one full locked frame of pixels
    pv0 = pv_cnt; fs0 = fs_cnt; pb0 = pat_bad; te0 = terr_cnt;
    run_to_vs(4);
    chk("frame_pv_count", 32'(pv_cnt - pv0), 32);
    chk("frame_fs_count", 32'(fs_cnt - fs0), 1);
    chk("frame_fs_at_00", 32'(fs_ok), 1);
    chk("frame_pattern", 32'(pat_bad - pb0), 0);
    chk("last_pix_x", 32'(pix_x), 7);
    chk("last_pix_y", 32'(pix_y), 3);
    chk("last_pix_data", 32'(pix_data), 32'h1807);
    chk("frame_no_err", 32'(terr_cnt - te0), 0);
    chk("frame_locked", 32'(locked), 1);

    // stretch active line 4 to 21 cycles
    te0 = terr_cnt;
    stretch_v = 4;
    run_to(5, 0);
    step();
    chk("stretch_err", 32'(timing_err), 1);
    chk("stretch_still_locked", 32'(locked), 1);
    step();
    chk("stretch_err_pulse", 32'(timing_err), 0);
    chk("stretch_unlocked", 32'(locked), 0);
    chk("stretch_h_meas", 32'(h_meas), 21);
    run_to_vs(6);
    step();
    chk("relock_early", 32'(locked), 0);
    run_to_vs(7);
    step();
    chk("relock", 32'(locked), 1);
    chk("stretch_single_err", 32'(terr_cnt - te0), 1);

    // drop one de cycle in active line 4 (7 pixels in that line)
    te0 = terr_cnt;
    drop_v = 4; drop_x = 3;
    run_to(5, 0);
    chk("drop_no_early_err", 32'(terr_cnt - te0), 0);
    step();
    chk("drop_err", 32'(timing_err), 1);
    step();
    chk("drop_unlocked", 32'(locked), 0);
    pv0 = pv_cnt;
    run_to_vs(9);
    step();
    chk("drop_no_pv", 32'(pv_cnt - pv0), 0);
    chk("drop_train", 32'(locked), 0);
    run_to_vs(10);
    step();
    chk("drop_relock", 32'(locked), 1);

    // asynchronous reset mid-line while locked
    run_to(3, 10);
    step();
    chk("pre_rst_pv", 32'(pix_valid), 1);
    chk("pre_rst_x", 32'(pix_x), 3);
    rst_n = 1'b0;
    #1;
    chk("arst_pix_valid", 32'(pix_valid), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_pix_x", 32'(pix_x), 0);
    chk("arst_pix_data", 32'(pix_data), 0);
    chk("arst_h_meas", 32'(h_meas), 0);
    chk("arst_v_meas", 32'(v_meas), 0);
    repeat (3) step();
    rst_n = 1'b1;
    pv0 = pv_cnt;
    run_to_vs(13);
    chk("arst_no_pv", 32'(pv_cnt - pv0), 0);
    chk("arst_not_locked", 32'(locked), 0);
    step();
    chk("arst_relock", 32'(locked), 1);

    // hs stuck high for 3000 cycles (vs masked too) while locked
    run_to(3, 0);
    te0 = terr_cnt;
    hs_hold = 3000;
    repeat (3000) step();
    chk("stuck_err_once", 32'(terr_cnt - te0), 1);
    chk("stuck_unlocked", 32'(locked), 0);
    step();
    step();
    chk("stuck_h_meas_sat", 32'(h_meas), 2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
